// File: rtl/conv_1x1_weight_feeder.sv
// Weight buffer for a 1x1 convolution engine: fills once through a write port,
// then streams every stored word in address order on each load request.
module conv_1x1_weight_feeder #(
  parameter int DATA_WIDTH                   = 32,
  parameter int WEIGHT_NUM                   = 256,
  parameter int POINTER_WIDTH_BUFFER_WEIGHTS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_clr,
  input  logic                  load_req,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_out,
  output logic                  wr_full,
  output logic                  busy,
  output logic                  done
);

  // state  | meaning
  // IDLE   | accepting writes / clear; waiting for load_req with a full buffer
  // STREAM | issuing one read per cycle with hold low
  // DONE   | last word on the output; restarts at once if a request is pending

  localparam int PW  = POINTER_WIDTH_BUFFER_WEIGHTS;
  localparam int WPW = PW + 1;
  localparam logic [WPW-1:0] LAST_WR = WPW'(WEIGHT_NUM - 1);
  localparam logic [PW-1:0]  LAST_RD = PW'(WEIGHT_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [WEIGHT_NUM];

  logic [WPW-1:0] wr_ptr;
  logic [PW-1:0]  rd_ptr, rd_ptr_nx, rd_addr;
  logic           pending, pending_nx;
  logic           rd_en;
  logic           wr_do, clr_do;

  assign clr_do = (state == IDLE) && wr_clr;
  assign wr_do  = (state == IDLE) && wr_en && !wr_clr && !wr_full;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_comb begin
    state_nx   = state;
    rd_ptr_nx  = rd_ptr;
    pending_nx = pending;
    rd_en      = 1'b0;
    rd_addr    = rd_ptr;
    case (state)
      IDLE: begin
        pending_nx = 1'b0;
        if (load_req && wr_full) begin
          state_nx  = STREAM;
          rd_ptr_nx = '0;
        end
      end
      STREAM: begin
        if (load_req) pending_nx = 1'b1;
        if (!hold) begin
          rd_en     = 1'b1;
          rd_ptr_nx = rd_ptr + PW'(1);
          if (rd_ptr == LAST_RD) state_nx = DONE;
        end
      end
      DONE: begin
        if (pending || load_req) begin
          // The first read of the next stream is issued here so the output has no gap.
          pending_nx = 1'b0;
          state_nx   = STREAM;
          rd_ptr_nx  = '0;
          if (!hold) begin
            rd_en     = 1'b1;
            rd_addr   = '0;
            rd_ptr_nx = PW'(1);
            if (LAST_RD == '0) state_nx = DONE;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      pending   <= 1'b0;
      wr_ptr    <= '0;
      wr_full   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nx;
      rd_ptr    <= rd_ptr_nx;
      pending   <= pending_nx;
      valid_out <= rd_en;
      if (clr_do) begin
        wr_ptr  <= '0;
        wr_full <= 1'b0;
      end else if (wr_do) begin
        wr_ptr <= wr_ptr + WPW'(1);
        if (wr_ptr == LAST_WR) wr_full <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (wr_do && !reset) mem[wr_ptr[PW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) weight_out <= '0;
    else if (rd_en) weight_out <= mem[rd_addr];
  end

endmodule

// File: tb/tb_conv_1x1_weight_feeder.sv
// Self-checking bench for conv_1x1_weight_feeder with a 4-word buffer:
// directed scenarios plus randomized traffic against a count-based stream model.
module tb_conv_1x1_weight_feeder;

  localparam int DW = 32;
  localparam int WN = 4;
  localparam int N  = 64;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_clr;
  logic          load_req;
  logic          hold;
  logic [DW-1:0] weight_out;
  logic          valid_out;
  logic          wr_full;
  logic          busy;
  logic          done;

  conv_1x1_weight_feeder #(
    .DATA_WIDTH(DW),
    .WEIGHT_NUM(WN),
    .POINTER_WIDTH_BUFFER_WEIGHTS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_clr(wr_clr),
    .load_req(load_req),
    .hold(hold),
    .weight_out(weight_out),
    .valid_out(valid_out),
    .wr_full(wr_full),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // per-cycle stimulus of the current scenario
  bit            s_ld[N], s_hold[N], s_rst[N], s_wr[N], s_clr[N];
  logic [DW-1:0] s_wd[N];
  // observed outputs
  bit            o_valid[N], o_done[N], o_busy[N], o_full[N];
  logic [DW-1:0] o_word[N];
  // expected outputs
  bit            e_valid[N], e_done[N], e_busy[N], e_full[N];
  logic [DW-1:0] e_word[N];

  // reference model: buffer contents, fill count and an abstract stream tracker
  logic [DW-1:0] m_mem[WN];
  int            m_wcount = 0;
  bit            m_full = 0;
  bit            m_busy = 0;
  int            m_issued = 0;
  bit            m_pend = 0;
  bit            m_valid = 0;
  logic [DW-1:0] m_word = '0;

  task automatic clear_stim();
    for (int c = 0; c < N; c++) begin
      s_ld[c] = 0; s_hold[c] = 0; s_rst[c] = 0; s_wr[c] = 0; s_clr[c] = 0; s_wd[c] = '0;
    end
  endtask

  // A stream is "WN reads in address order, one per unheld cycle, each word
  // visible the cycle after its read; done rides on the last word".
  task automatic model_run(input int n);
    bit can_issue;
    bit start;
    for (int c = 0; c < n; c++) begin
      e_busy[c]  = m_busy;
      e_full[c]  = m_full;
      e_done[c]  = m_busy && (m_issued == WN);
      e_valid[c] = m_valid;
      e_word[c]  = m_word;
      if (s_rst[c]) begin
        m_busy = 0; m_pend = 0; m_full = 0; m_wcount = 0; m_issued = 0;
        m_valid = 0; m_word = '0;
        continue;
      end
      can_issue = 0;
      if (!m_busy) begin
        start = s_ld[c] && m_full;
        if (s_clr[c]) begin
          m_wcount = 0; m_full = 0;
        end else if (s_wr[c] && !m_full) begin
          m_mem[m_wcount] = s_wd[c];
          m_wcount++;
          if (m_wcount == WN) m_full = 1;
        end
        if (start) begin
          m_busy = 1; m_issued = 0;
        end
      end else if (m_issued == WN) begin
        if (m_pend || s_ld[c]) begin
          m_pend = 0; m_issued = 0; can_issue = 1;
        end else begin
          m_busy = 0;
        end
      end else begin
        if (s_ld[c]) m_pend = 1;
        can_issue = 1;
      end
      if (can_issue && !s_hold[c]) begin
        m_word = m_mem[m_issued];
        m_issued++;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // Drives n cycles of stimulus (cycle 0 starts now) and compares every cycle.
  task automatic run_scenario(input string name, input int n);
    model_run(n);
    for (int c = 0; c < n; c++) begin
      reset = s_rst[c]; wr_en = s_wr[c]; wr_data = s_wd[c]; wr_clr = s_clr[c];
      load_req = s_ld[c]; hold = s_hold[c];
      o_valid[c] = valid_out; o_done[c] = done; o_busy[c] = busy;
      o_full[c] = wr_full; o_word[c] = weight_out;
      tests += 5;
      if (valid_out !== e_valid[c]) begin
        fails++;
        $display("FAIL %s valid_out cycle %0d: got %b expected %b", name, c, valid_out, e_valid[c]);
      end
      if (done !== e_done[c]) begin
        fails++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, c, done, e_done[c]);
      end
      if (busy !== e_busy[c]) begin
        fails++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, e_busy[c]);
      end
      if (wr_full !== e_full[c]) begin
        fails++;
        $display("FAIL %s wr_full cycle %0d: got %b expected %b", name, c, wr_full, e_full[c]);
      end
      if (weight_out !== e_word[c]) begin
        fails++;
        $display("FAIL %s weight_out cycle %0d: got %h expected %h", name, c, weight_out, e_word[c]);
      end
      @(posedge clk); #1;
    end
    reset = 0; wr_en = 0; wr_clr = 0; load_req = 0; hold = 0;
  endtask

  task automatic test_reset();
    reset = 1; wr_en = 0; wr_data = '0; wr_clr = 0; load_req = 0; hold = 0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    tests++;
    if ({valid_out, busy, done, wr_full} !== 4'b0000 || weight_out !== '0) begin
      fails++;
      $display("FAIL reset outputs: got v=%b b=%b d=%b f=%b w=%h expected all zero",
               valid_out, busy, done, wr_full, weight_out);
    end
    m_busy = 0; m_pend = 0; m_full = 0; m_wcount = 0; m_issued = 0; m_valid = 0; m_word = '0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] w[WN];
    w[0] = 32'h3F800000; w[1] = 32'h40000000; w[2] = 32'h40400000; w[3] = 32'h40800000;
    clear_stim();
    for (int i = 0; i < WN; i++) begin s_wr[i] = 1; s_wd[i] = w[i]; end
    s_ld[5] = 1;
    run_scenario("basic", 14);
    tests++;
    if (o_full[5] !== 1'b1) begin
      fails++;
      $display("FAIL basic full_at_T: got %b expected 1", o_full[5]);
    end
    for (int c = 5; c < 14; c++) begin
      tests += 3;
      if (o_valid[c] !== (c >= 7 && c <= 10)) begin
        fails++;
        $display("FAIL basic valid_window cycle T+%0d: got %b", c - 5, o_valid[c]);
      end
      if (o_done[c] !== (c == 10)) begin
        fails++;
        $display("FAIL basic done_at_T+5 cycle T+%0d: got %b", c - 5, o_done[c]);
      end
      if (o_busy[c] !== (c >= 6 && c <= 10)) begin
        fails++;
        $display("FAIL basic busy_window cycle T+%0d: got %b", c - 5, o_busy[c]);
      end
    end
    for (int i = 0; i < WN; i++) begin
      tests++;
      if (o_word[7 + i] !== w[i]) begin
        fails++;
        $display("FAIL basic word%0d: got %h expected %h", i, o_word[7 + i], w[i]);
      end
    end
  endtask

  task automatic test_hold();
    int nvalid;
    clear_stim();
    s_ld[0] = 1; s_hold[2] = 1; s_hold[3] = 1;
    run_scenario("hold", 12);
    nvalid = 0;
    for (int c = 0; c < 12; c++) nvalid += int'(o_valid[c]);
    tests += 4;
    if (o_valid[3] !== 1'b0 || o_valid[4] !== 1'b0) begin
      fails++;
      $display("FAIL hold gap: got valid T+3=%b T+4=%b expected 0 0", o_valid[3], o_valid[4]);
    end
    if (o_done[7] !== 1'b1) begin
      fails++;
      $display("FAIL hold done_at_T+7: got %b expected 1", o_done[7]);
    end
    if (o_done[5] !== 1'b0) begin
      fails++;
      $display("FAIL hold early_done: got %b expected 0", o_done[5]);
    end
    if (nvalid != WN) begin
      fails++;
      $display("FAIL hold valid_count: got %0d expected %0d", nvalid, WN);
    end
  endtask

  task automatic test_short_fill();
    int nbusy;
    clear_stim();
    s_clr[0] = 1;
    s_wr[1] = 1; s_wd[1] = $urandom;
    s_wr[2] = 1; s_wd[2] = $urandom;
    s_ld[4] = 1;
    s_wr[8] = 1; s_wd[8] = $urandom;
    s_wr[9] = 1; s_wd[9] = $urandom;
    s_wr[11] = 1; s_wd[11] = $urandom;
    s_ld[13] = 1;
    run_scenario("short_fill", 22);
    nbusy = 0;
    for (int c = 0; c <= 8; c++) nbusy += int'(o_busy[c]);
    tests += 5;
    if (nbusy != 0) begin
      fails++;
      $display("FAIL short_fill ignored_load: got %0d busy cycles expected 0", nbusy);
    end
    if (o_word[15] !== s_wd[1]) begin
      fails++; $display("FAIL short_fill word0: got %h expected %h", o_word[15], s_wd[1]);
    end
    if (o_word[16] !== s_wd[2]) begin
      fails++; $display("FAIL short_fill word1: got %h expected %h", o_word[16], s_wd[2]);
    end
    if (o_word[17] !== s_wd[8]) begin
      fails++; $display("FAIL short_fill word2: got %h expected %h", o_word[17], s_wd[8]);
    end
    if (o_word[18] !== s_wd[9]) begin
      fails++; $display("FAIL short_fill word3_not_fifth: got %h expected %h", o_word[18], s_wd[9]);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    s_ld[0] = 1; s_ld[3] = 1; s_ld[4] = 1;
    run_scenario("back_to_back", 16);
    for (int c = 0; c < 16; c++) begin
      tests += 2;
      if (o_valid[c] !== (c >= 2 && c <= 9)) begin
        fails++;
        $display("FAIL back_to_back valid_window cycle T+%0d: got %b", c, o_valid[c]);
      end
      if (o_done[c] !== (c == 5 || c == 9)) begin
        fails++;
        $display("FAIL back_to_back done_pulses cycle T+%0d: got %b", c, o_done[c]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    clear_stim();
    s_ld[0] = 1; s_rst[3] = 1; s_ld[6] = 1;
    for (int i = 0; i < WN; i++) begin s_wr[8 + i] = 1; s_wd[8 + i] = $urandom; end
    s_ld[13] = 1;
    run_scenario("reset_abort", 22);
    ndone = 0;
    for (int c = 0; c <= 12; c++) ndone += int'(o_done[c]);
    tests += 5;
    if (o_valid[4] !== 1'b0 || o_busy[4] !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort stop: got valid=%b busy=%b expected 0 0", o_valid[4], o_busy[4]);
    end
    if (ndone != 0) begin
      fails++; $display("FAIL reset_abort no_done: got %0d pulses expected 0", ndone);
    end
    if (o_full[5] !== 1'b0) begin
      fails++; $display("FAIL reset_abort full_cleared: got %b expected 0", o_full[5]);
    end
    if (o_busy[7] !== 1'b0) begin
      fails++; $display("FAIL reset_abort load_ignored: got busy %b expected 0", o_busy[7]);
    end
    if (o_word[15] !== s_wd[8]) begin
      fails++; $display("FAIL reset_abort reload_word0: got %h expected %h", o_word[15], s_wd[8]);
    end
  endtask

  task automatic test_clear();
    clear_stim();
    s_clr[0] = 1; s_wr[0] = 1; s_wd[0] = $urandom;
    for (int i = 0; i < WN; i++) begin s_wr[2 + i] = 1; s_wd[2 + i] = $urandom; end
    s_ld[7] = 1;
    run_scenario("clear", 16);
    tests += 3;
    if (o_full[1] !== 1'b0) begin
      fails++; $display("FAIL clear full_dropped: got %b expected 0", o_full[1]);
    end
    if (o_word[9] !== s_wd[2]) begin
      fails++; $display("FAIL clear overwrite_addr0: got %h expected %h", o_word[9], s_wd[2]);
    end
    if (o_word[12] !== s_wd[5]) begin
      fails++; $display("FAIL clear overwrite_addr3: got %h expected %h", o_word[12], s_wd[5]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      s_clr[0] = 1;
      for (int i = 0; i < WN; i++) begin s_wr[1 + i] = 1; s_wd[1 + i] = $urandom; end
      for (int c = 5; c < 30; c++) begin
        s_ld[c]   = ($urandom_range(3) == 0);
        s_hold[c] = ($urandom_range(2) == 0);
        s_wr[c]   = ($urandom_range(1) == 0);
        s_wd[c]   = $urandom;
      end
      run_scenario("random", 60);
    end
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_data = '0; wr_clr = 0; load_req = 0; hold = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_hold();
    test_short_fill();
    test_back_to_back();
    test_reset_abort();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
